// File: rtl/instruction_fetch_unit.sv
// IF-stage requester for the instruction memory: owns the PC, captures the returned
// word into a small fetch queue and hands {pc, inst} to decode over valid/ready.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FQ_DEPTH   = 2,
  parameter int          IMEM_WORDS = 51
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic        fault_o
);

  localparam int          PW         = $clog2(FQ_DEPTH);
  localparam int          CW         = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FQ_DEPTH);
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FAULT
  } state_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_pc, w_pc_next;
  logic [CW-1:0]   r_count, w_count_next;
  logic [PW-1:0]   r_rd_ptr, w_rd_ptr_next;
  logic [PW-1:0]   r_wr_ptr, w_wr_ptr_next;
  logic            r_fault, w_fault_next;

  logic [31:0]     r_q_pc   [FQ_DEPTH];
  logic [31:0]     r_q_inst [FQ_DEPTH];

  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_can_push;
  logic            w_fetch_fault;

  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid && id_ready_i;
  assign w_can_push    = (r_count < DEPTH_C) || w_pop;
  assign w_fetch_fault = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= IMEM_LIMIT);

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_count_next  = r_count;
    w_rd_ptr_next = r_rd_ptr;
    w_wr_ptr_next = r_wr_ptr;
    w_fault_next  = r_fault;
    w_push        = 1'b0;

    if (redirect_i) begin
      // Flush wins over any pop or push in the same cycle.
      w_state_next  = S_FETCH;
      w_pc_next     = redirect_pc_i;
      w_count_next  = '0;
      w_rd_ptr_next = '0;
      w_wr_ptr_next = '0;
      w_fault_next  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_FETCH;
        S_FETCH: begin
          if (w_fetch_fault) begin
            w_state_next = S_FAULT;
            w_fault_next = 1'b1;
          end else if (w_can_push) begin
            w_push    = 1'b1;
            w_pc_next = r_pc + 32'd4;
          end
        end
        S_FAULT: w_state_next = S_FAULT;
        default: w_state_next = S_IDLE;
      endcase

      if (w_pop)  w_rd_ptr_next = r_rd_ptr + PW'(1);
      if (w_push) w_wr_ptr_next = r_wr_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CW'(1);
        2'b01:   w_count_next = r_count - CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_count  <= w_count_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_wr_ptr <= w_wr_ptr_next;
      r_fault  <= w_fault_next;
    end
  end

  // Queue storage is left unreset; every head output is gated by w_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_inst[r_wr_ptr] <= inst_i;
    end
  end

  assign pc_o       = r_pc;
  assign id_valid_o = w_valid;
  assign id_inst_o  = w_valid ? r_q_inst[r_rd_ptr] : NOP;
  assign id_pc_o    = w_valid ? r_q_pc[r_rd_ptr] : 32'd0;
  assign id_pc4_o   = w_valid ? (r_q_pc[r_rd_ptr] + 32'd4) : 32'd0;
  assign fault_o    = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a cycle table covering fill/stall/drain,
// redirects and range/alignment faults, plus a hand sequence for asynchronous reset.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_inst_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc4_o;
  logic        fault_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FQ_DEPTH  (2),
    .IMEM_WORDS(51)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_o         (pc_o),
    .inst_i       (inst_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_ready_i   (id_ready_i),
    .id_valid_o   (id_valid_o),
    .id_inst_o    (id_inst_o),
    .id_pc_o      (id_pc_o),
    .id_pc4_o     (id_pc4_o),
    .fault_o      (fault_o)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'hA000_0003 ^ (a << 8);
  endfunction

  assign inst_i = imem(pc_o);

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_id_pc;
    logic        e_fault;
  } vec_t;

  vec_t vecs[27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic [31:0] e_pc, input logic e_valid,
                               input logic [31:0] e_id_pc, input logic e_fault);
    logic [31:0] e_inst, e_pcx, e_pc4;
    e_inst = e_valid ? imem(e_id_pc) : NOP;
    e_pcx  = e_valid ? e_id_pc : 32'd0;
    e_pc4  = e_valid ? e_id_pc + 32'd4 : 32'd0;
    chk($sformatf("v%0d pc_o", idx), pc_o, e_pc);
    chk($sformatf("v%0d id_valid", idx), {31'd0, id_valid_o}, {31'd0, e_valid});
    chk($sformatf("v%0d id_pc", idx), id_pc_o, e_pcx);
    chk($sformatf("v%0d id_inst", idx), id_inst_o, e_inst);
    chk($sformatf("v%0d id_pc4", idx), id_pc4_o, e_pc4);
    chk($sformatf("v%0d fault", idx), {31'd0, fault_o}, {31'd0, e_fault});
    $display("cycle %0d: rdy=%0b redir=%0b pc_o=%08h valid=%0b id_pc=%08h fault=%0b",
             idx, id_ready_i, redirect_i, pc_o, id_valid_o, id_pc_o, fault_o);
  endtask

  // Drive inputs just after a rising edge, check before the next one, then clock.
  task automatic step(input int idx, input logic rdy, input logic redir, input logic [31:0] rpc,
                      input logic [31:0] e_pc, input logic e_valid,
                      input logic [31:0] e_id_pc, input logic e_fault);
    id_ready_i    = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    @(negedge clk);
    check_outputs(idx, e_pc, e_valid, e_id_pc, e_fault);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rdy, redir, rpc, exp pc_o, exp valid, exp id_pc, exp fault
    vecs[0]  = '{1'b1, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00, 1'b0}; // IDLE
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00, 1'b0}; // FETCH, first push
    vecs[2]  = '{1'b0, 1'b0, 32'h0,  32'h04, 1'b1, 32'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h00, 1'b0}; // full
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  32'h08, 1'b1, 32'h00, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,  32'h08, 1'b1, 32'h00, 1'b0}; // full + pop
    vecs[7]  = '{1'b1, 1'b0, 32'h0,  32'h0C, 1'b1, 32'h04, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  32'h10, 1'b1, 32'h08, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32'h20, 32'h14, 1'b1, 32'h0C, 1'b0}; // redirect, 2 queued
    vecs[10] = '{1'b1, 1'b0, 32'h0,  32'h20, 1'b0, 32'h00, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,  32'h24, 1'b1, 32'h20, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 32'hC0, 32'h28, 1'b1, 32'h24, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h0,  32'hC0, 1'b0, 32'h00, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,  32'hC4, 1'b1, 32'hC0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 32'h0,  32'hC8, 1'b1, 32'hC0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 32'h0,  32'hCC, 1'b1, 32'hC4, 1'b0}; // 0xCC out of range
    vecs[17] = '{1'b1, 1'b0, 32'h0,  32'hCC, 1'b1, 32'hC4, 1'b1}; // drains in FAULT
    vecs[18] = '{1'b1, 1'b0, 32'h0,  32'hCC, 1'b1, 32'hC8, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 32'h0,  32'hCC, 1'b0, 32'h00, 1'b1};
    vecs[20] = '{1'b1, 1'b1, 32'h0,  32'hCC, 1'b0, 32'h00, 1'b1}; // recover
    vecs[21] = '{1'b1, 1'b0, 32'h0,  32'h00, 1'b0, 32'h00, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 32'h0,  32'h04, 1'b1, 32'h00, 1'b0};
    vecs[23] = '{1'b1, 1'b1, 32'h6,  32'h08, 1'b1, 32'h04, 1'b0}; // misaligned target
    vecs[24] = '{1'b1, 1'b0, 32'h0,  32'h06, 1'b0, 32'h00, 1'b0};
    vecs[25] = '{1'b1, 1'b0, 32'h0,  32'h06, 1'b0, 32'h00, 1'b1};
    vecs[26] = '{1'b1, 1'b0, 32'h0,  32'h06, 1'b0, 32'h00, 1'b1};

    rst_n         = 1'b0;
    id_ready_i    = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    #12;
    check_outputs(-1, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++)
      step(i, vecs[i].rdy, vecs[i].redir, vecs[i].rpc,
           vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_id_pc, vecs[i].e_fault);

    // Fill the queue, run into the range fault, then pulse reset between edges.
    step(100, 1'b0, 1'b1, 32'hC4, 32'h06, 1'b0, 32'h00, 1'b1);
    step(101, 1'b0, 1'b0, 32'h0,  32'hC4, 1'b0, 32'h00, 1'b0);
    step(102, 1'b0, 1'b0, 32'h0,  32'hC8, 1'b1, 32'hC4, 1'b0);
    step(103, 1'b0, 1'b0, 32'h0,  32'hCC, 1'b1, 32'hC4, 1'b0);
    id_ready_i = 1'b0;
    @(negedge clk);
    check_outputs(104, 32'hCC, 1'b1, 32'hC4, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs(105, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs(106, 32'h0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    step(107, 1'b1, 1'b0, 32'h0, 32'h00, 1'b0, 32'h00, 1'b0);
    step(108, 1'b1, 1'b0, 32'h0, 32'h00, 1'b0, 32'h00, 1'b0);
    step(109, 1'b1, 1'b0, 32'h0, 32'h04, 1'b1, 32'h00, 1'b0);
    step(110, 1'b1, 1'b0, 32'h0, 32'h08, 1'b1, 32'h04, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
